// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode constants,
// sequencer state encoding, IR field positions and the opcode-class decode.
package cpu_ctrl_pkg;

  localparam int unsigned OpcodeW = 5;

  // IR field positions (LSB of each field; widths come from OPW / RW).
  localparam int unsigned OpLsb = 27;
  localparam int unsigned RaLsb = 23;
  localparam int unsigned RbLsb = 19;
  localparam int unsigned RcLsb = 15;

  localparam logic [OpcodeW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcodeW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcodeW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpcodeW-1:0] OpOr   = 5'b00110;
  localparam logic [OpcodeW-1:0] OpShr  = 5'b00111;
  localparam logic [OpcodeW-1:0] OpShl  = 5'b01000;
  localparam logic [OpcodeW-1:0] OpRor  = 5'b01001;
  localparam logic [OpcodeW-1:0] OpRol  = 5'b01010;
  localparam logic [OpcodeW-1:0] OpMul  = 5'b01111;
  localparam logic [OpcodeW-1:0] OpDiv  = 5'b10000;
  localparam logic [OpcodeW-1:0] OpNeg  = 5'b10001;
  localparam logic [OpcodeW-1:0] OpNot  = 5'b10010;
  localparam logic [OpcodeW-1:0] OpNop  = 5'b11010;
  localparam logic [OpcodeW-1:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu3,
    ClsUnary,
    ClsMulDiv,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  function automatic op_class_e op_class(input logic [OpcodeW-1:0] op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol: cls = ClsAlu3;
      OpNeg, OpNot:                                          cls = ClsUnary;
      OpMul, OpDiv:                                          cls = ClsMulDiv;
      OpNop:                                                 cls = ClsNop;
      OpHalt:                                                cls = ClsHalt;
      default:                                               cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot GPR strobe decoder.
//   en_i     : strobe enable; output is all-zero when low
//   sel_i    : RW-bit register number
//   onehot_o : NREG-bit one-hot strobe (zero when disabled)
module reg_select_decoder #(
  parameter int unsigned RW   = 4,
  parameter int unsigned NREG = 16
) (
  input  logic            en_i,
  input  logic [RW-1:0]   sel_i,
  output logic [NREG-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot_o[i] = en_i && (sel_i == RW'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit bus datapath. Sequences fetch (T0-T2)
// and execute (T3-T6) and drives every datapath strobe as a decode of the
// current state and the latched IR fields.
//   Clock, Clear        : rising-edge clock, synchronous active-high clear
//   Run                 : level; start / continue execution
//   IR                  : latched instruction (valid from T3 onward)
//   MemDone             : memory read data valid during fetch
//   PCout..Zlowout      : bus source selects
//   MARin..LOin         : register load enables
//   IncPC, Read         : PC increment to ALU; memory read / MDR source
//   Rin, Rout           : one-hot GPR load / bus-drive strobes
//   CONTROL             : ALU operation
//   Busy/Halted/Illegal : status
//   InstrCount          : retired instructions (wrapping)
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned RW   = 4,
  parameter int unsigned NREG = 16,
  parameter int unsigned CNTW = 16
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Run,
  input  logic [31:0]     IR,
  input  logic            MemDone,
  output logic            PCout,
  output logic            MDRout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zhighin,
  output logic            Zlowin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  CONTROL,
  output logic            Busy,
  output logic            Halted,
  output logic            Illegal,
  output logic [CNTW-1:0] InstrCount
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q;
  logic            illegal_q;

  logic [OPW-1:0]  op;
  logic [RW-1:0]   ra, rb, rc;
  op_class_e       cls;

  logic            rout_en, rin_en;
  logic [RW-1:0]   rout_sel, rin_sel;
  logic            retire, count_en;
  state_e          after_retire;

  assign op  = IR[OpLsb +: OPW];
  assign ra  = IR[RaLsb +: RW];
  assign rb  = IR[RbLsb +: RW];
  assign rc  = IR[RcLsb +: RW];
  assign cls = op_class(op);

  logic unused_ir;
  assign unused_ir = ^IR[RcLsb-1:0];

  // Last execute state of each class; also where the retire counter ticks.
  assign retire = (state_q == StT3 && cls == ClsNop)   ||
                  (state_q == StT4 && cls == ClsUnary) ||
                  (state_q == StT5 && cls == ClsAlu3)  ||
                  (state_q == StT6);
  assign count_en     = retire || (state_q == StT3 && cls == ClsHalt);
  assign after_retire = Run ? StT0 : StIdle;

  // State register
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (Run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (MemDone) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        case (cls)
          ClsAlu3, ClsUnary, ClsMulDiv: state_d = StT4;
          ClsNop:                       state_d = after_retire;
          default:                      state_d = StHalt;
        endcase
      end
      StT4:   state_d = (cls == ClsUnary) ? after_retire : StT5;
      StT5:   state_d = (cls == ClsMulDiv) ? StT6 : after_retire;
      StT6:   state_d = after_retire;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; everything is held low while Clear is asserted so an
  // aborted instruction never leaves a partial register write behind.
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zhighin  = 1'b0;
    Zlowin   = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    CONTROL  = '0;
    rout_en  = 1'b0;
    rout_sel = '0;
    rin_en   = 1'b0;
    rin_sel  = '0;
    if (!Clear) begin
      unique case (state_q)
        StT0: begin
          PCout  = 1'b1;
          MARin  = 1'b1;
          IncPC  = 1'b1;
          Zlowin = 1'b1;
        end
        StT1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
          // PC takes the incremented value only on the completing cycle.
          if (MemDone) begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
          end
        end
        StT2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        StT3: begin
          case (cls)
            ClsAlu3: begin
              rout_en  = 1'b1;
              rout_sel = rb;
              Yin      = 1'b1;
            end
            ClsUnary: begin
              rout_en  = 1'b1;
              rout_sel = rb;
              CONTROL  = op;
              Zhighin  = 1'b1;
              Zlowin   = 1'b1;
            end
            ClsMulDiv: begin
              rout_en  = 1'b1;
              rout_sel = ra;
              Yin      = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          case (cls)
            ClsAlu3, ClsMulDiv: begin
              rout_en  = 1'b1;
              rout_sel = (cls == ClsAlu3) ? rc : rb;
              CONTROL  = op;
              Zhighin  = 1'b1;
              Zlowin   = 1'b1;
            end
            ClsUnary: begin
              Zlowout = 1'b1;
              rin_en  = 1'b1;
              rin_sel = ra;
            end
            default: ;
          endcase
        end
        StT5: begin
          case (cls)
            ClsAlu3: begin
              Zlowout = 1'b1;
              rin_en  = 1'b1;
              rin_sel = ra;
            end
            ClsMulDiv: begin
              Zlowout = 1'b1;
              LOin    = 1'b1;
            end
            default: ;
          endcase
        end
        StT6: begin
          if (cls == ClsMulDiv) begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy       = !Clear && (state_q != StIdle) && (state_q != StHalt);
  assign Halted     = (state_q == StHalt);
  assign Illegal    = illegal_q;
  assign InstrCount = count_q;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (count_en) begin
        count_q <= count_q + CNTW'(1);
      end
      if (state_q == StT3 && cls == ClsIllegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  reg_select_decoder #(
    .RW   (RW),
    .NREG (NREG)
  ) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

  reg_select_decoder #(
    .RW   (RW),
    .NREG (NREG)
  ) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (Rin)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, Run, MemDone;
  logic [31:0] IR;

  logic        PCout, MDRout, Zhighout, Zlowout, MARin, PCin, MDRin, IRin, Yin;
  logic        Zhighin, Zlowin, HIin, LOin, IncPC, Read, Busy, Halted, Illegal;
  logic [15:0] Rin, Rout, InstrCount;
  logic [4:0]  CONTROL;

  // Narrow-counter instance sharing all stimulus, used to observe wrap-around.
  logic        w_PCout, w_MDRout, w_Zhighout, w_Zlowout, w_MARin, w_PCin, w_MDRin, w_IRin;
  logic        w_Yin, w_Zhighin, w_Zlowin, w_HIin, w_LOin, w_IncPC, w_Read;
  logic        w_Busy, w_Halted, w_Illegal;
  logic [15:0] w_Rin, w_Rout;
  logic [4:0]  w_CONTROL;
  logic [2:0]  w_InstrCount;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemDone(MemDone),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .CONTROL(CONTROL),
    .Busy(Busy), .Halted(Halted), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  control_sequencer #(.CNTW(3)) dut_w (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemDone(MemDone),
    .PCout(w_PCout), .MDRout(w_MDRout), .Zhighout(w_Zhighout), .Zlowout(w_Zlowout),
    .MARin(w_MARin), .PCin(w_PCin), .MDRin(w_MDRin), .IRin(w_IRin), .Yin(w_Yin),
    .Zhighin(w_Zhighin), .Zlowin(w_Zlowin), .HIin(w_HIin), .LOin(w_LOin),
    .IncPC(w_IncPC), .Read(w_Read), .Rin(w_Rin), .Rout(w_Rout), .CONTROL(w_CONTROL),
    .Busy(w_Busy), .Halted(w_Halted), .Illegal(w_Illegal), .InstrCount(w_InstrCount)
  );

  typedef struct packed {
    logic pcout, mdrout, zhighout, zlowout, marin, pcin, mdrin, irin, yin;
    logic zhighin, zlowin, hiin, loin, incpc, read;
    logic [15:0] rin, rout;
    logic [4:0]  control;
    logic busy, halted, illegal;
  } obs_t;

  typedef struct {
    logic        memdone;
    logic        run;
    logic [31:0] ir;
    obs_t        exp;
    string       tag;
  } step_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    logic        run_last;
    string       name;
  } vec_t;

  step_t sbq[$];
  vec_t  vecs[10];
  int    checks = 0;
  int    failures = 0;
  int    exp_count = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pcout = PCout;     o.mdrout = MDRout;   o.zhighout = Zhighout; o.zlowout = Zlowout;
    o.marin = MARin;     o.pcin = PCin;       o.mdrin = MDRin;       o.irin = IRin;
    o.yin = Yin;         o.zhighin = Zhighin; o.zlowin = Zlowin;     o.hiin = HIin;
    o.loin = LOin;       o.incpc = IncPC;     o.read = Read;         o.rin = Rin;
    o.rout = Rout;       o.control = CONTROL; o.busy = Busy;         o.halted = Halted;
    o.illegal = Illegal;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    if (InstrCount !== 16'(exp_count) || w_InstrCount !== 3'(exp_count)) begin
      failures++;
      $display("FAIL %s count got=%0d/%0d exp=%0d/%0d", tag, InstrCount, w_InstrCount,
               16'(exp_count), 3'(exp_count));
    end
  endtask

  task automatic push(input logic md, input logic rn, input logic [31:0] ir,
                      input obs_t e, input string tag);
    step_t s;
    s.memdone = md; s.run = rn; s.ir = ir; s.exp = e; s.tag = tag;
    sbq.push_back(s);
  endtask

  // Expected per-cycle strobes for one instruction, starting in T0.
  // cut > 0 keeps only the first cut cycles (for an aborted instruction).
  task automatic push_instr(input logic [31:0] ir, input int waits, input logic run_last,
                            input int cut, input string name);
    step_t loc[$];
    step_t s;
    obs_t  b, e;
    logic [4:0]  op;
    logic [15:0] ra1, rb1, rc1;
    bit alu3, unary, muldiv, retires;
    op  = ir[31:27];
    ra1 = 16'(1) << ir[26:23];
    rb1 = 16'(1) << ir[22:19];
    rc1 = 16'(1) << ir[18:15];
    alu3   = (op >= 5'b00011 && op <= 5'b01010);
    unary  = (op == 5'b10001 || op == 5'b10010);
    muldiv = (op == 5'b01111 || op == 5'b10000);
    retires = alu3 || unary || muldiv || op == 5'b11010;
    b = '0; b.busy = 1'b1;
    s.ir = ir; s.run = 1'b1; s.memdone = 1'b0;
    e = b; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1;
    s.exp = e; s.tag = {name, "_t0"}; loc.push_back(s);
    for (int w = 0; w < waits; w++) begin
      e = b; e.read = 1; e.mdrin = 1;
      s.exp = e; s.tag = {name, "_t1wait"}; loc.push_back(s);
    end
    e = b; e.read = 1; e.mdrin = 1; e.zlowout = 1; e.pcin = 1;
    s.memdone = 1'b1; s.exp = e; s.tag = {name, "_t1done"}; loc.push_back(s);
    s.memdone = 1'b0;
    e = b; e.mdrout = 1; e.irin = 1;
    s.exp = e; s.tag = {name, "_t2"}; loc.push_back(s);
    if (alu3) begin
      e = b; e.rout = rb1; e.yin = 1;                               s.exp = e; s.tag = {name, "_t3"}; loc.push_back(s);
      e = b; e.rout = rc1; e.control = op; e.zhighin = 1; e.zlowin = 1; s.exp = e; s.tag = {name, "_t4"}; loc.push_back(s);
      e = b; e.zlowout = 1; e.rin = ra1;                            s.exp = e; s.tag = {name, "_t5"}; loc.push_back(s);
    end else if (unary) begin
      e = b; e.rout = rb1; e.control = op; e.zhighin = 1; e.zlowin = 1; s.exp = e; s.tag = {name, "_t3"}; loc.push_back(s);
      e = b; e.zlowout = 1; e.rin = ra1;                            s.exp = e; s.tag = {name, "_t4"}; loc.push_back(s);
    end else if (muldiv) begin
      e = b; e.rout = ra1; e.yin = 1;                               s.exp = e; s.tag = {name, "_t3"}; loc.push_back(s);
      e = b; e.rout = rb1; e.control = op; e.zhighin = 1; e.zlowin = 1; s.exp = e; s.tag = {name, "_t4"}; loc.push_back(s);
      e = b; e.zlowout = 1; e.loin = 1;                             s.exp = e; s.tag = {name, "_t5"}; loc.push_back(s);
      e = b; e.zhighout = 1; e.hiin = 1;                            s.exp = e; s.tag = {name, "_t6"}; loc.push_back(s);
    end else begin
      e = b; s.exp = e; s.tag = {name, "_t3"}; loc.push_back(s);
    end
    if (retires) begin
      s = loc.pop_back(); s.run = run_last; loc.push_back(s);
    end
    for (int i = 0; i < loc.size(); i++) begin
      if (cut <= 0 || i < cut) sbq.push_back(loc[i]);
    end
    if (cut <= 0 && (retires || op == 5'b11011)) exp_count++;
  endtask

  // Apply queued stimulus one cycle at a time and compare on the falling edge.
  task automatic drain();
    step_t s;
    obs_t  got;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      MemDone = s.memdone; Run = s.run; IR = s.ir;
      @(negedge Clock);
      got = sample();
      check_obs(s.tag, got, s.exp);
      checks++;
      if ($countones({PCout, MDRout, Zhighout, Zlowout, Rout}) > 1 || $countones(Rin) > 1) begin
        failures++;
        $display("FAIL bus_onehot %s got_src=%b rin=%h exp=at_most_one", s.tag,
                 {PCout, MDRout, Zhighout, Zlowout, Rout}, Rin);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1; Run = 1'b0; MemDone = 1'b0;
    @(posedge Clock); @(posedge Clock); #1;
    Clear = 1'b0;
    exp_count = 0;
  endtask

  obs_t idle_rec, halt_rec, ill_rec, got;
  logic [31:0] prev_run;

  initial begin
    Clear = 1'b1; Run = 1'b0; MemDone = 1'b0; IR = '0;
    idle_rec = '0;
    halt_rec = '0; halt_rec.halted = 1'b1;
    ill_rec = halt_rec; ill_rec.illegal = 1'b1;

    vecs[0] = '{32'h1A920000, 0, 1'b1, "add_r5_r2_r4"};
    vecs[1] = '{32'h1A920000, 3, 1'b1, "add_wait3"};
    vecs[2] = '{32'h79880000, 0, 1'b1, "mul_r3_r1"};
    vecs[3] = '{mk(5'b00100, 4'd1, 4'd2, 4'd3), 1, 1'b0, "sub_stop"};
    vecs[4] = '{mk(5'b10000, 4'd9, 4'd10, 4'd0), 0, 1'b1, "div_r9_r10"};
    vecs[5] = '{mk(5'b10010, 4'd15, 4'd0, 4'd0), 2, 1'b1, "not_r15_r0"};
    vecs[6] = '{mk(5'b00101, 4'd0, 4'd15, 4'd14), 0, 1'b1, "and_r0"};
    vecs[7] = '{mk(5'b11010, 4'd0, 4'd0, 4'd0), 1, 1'b0, "nop_stop"};
    vecs[8] = '{mk(5'b01010, 4'd12, 4'd13, 4'd11), 0, 1'b1, "rol"};
    vecs[9] = '{32'h8BB00000, 0, 1'b0, "neg_r7_r6"};

    // Reset and idle with Run low.
    do_clear();
    push(1'b0, 1'b0, 32'h0, idle_rec, "idle_run0");
    drain();
    check_count("reset_count");

    // Table of instructions, back to back or restarted from IDLE.
    prev_run = 0;
    for (int v = 0; v < 10; v++) begin
      if (prev_run == 0) push(1'b0, 1'b1, 32'h0, idle_rec, {vecs[v].name, "_idle"});
      push_instr(vecs[v].ir, vecs[v].waits, vecs[v].run_last, 0, vecs[v].name);
      drain();
      check_count({vecs[v].name, "_count"});
      prev_run = {31'b0, vecs[v].run_last};
    end
    push(1'b0, 1'b0, 32'h0, idle_rec, "table_end_idle");
    drain();

    // neg then halt: HALT holds with Run still high.
    do_clear();
    push(1'b0, 1'b1, 32'h0, idle_rec, "nh_idle");
    push_instr(32'h8BB00000, 0, 1'b1, 0, "nh_neg");
    push_instr(32'hD8000000, 0, 1'b1, 0, "nh_halt");
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 32'hD8000000, halt_rec, "halt_hold");
    drain();
    check_count("halt_count");

    // Illegal opcode: halts, flags, does not count.
    do_clear();
    push(1'b0, 1'b1, 32'h0, idle_rec, "ill_idle");
    push_instr(32'hF8000000, 1, 1'b1, 0, "ill");
    for (int i = 0; i < 2; i++) push(1'b1, 1'b1, 32'hF8000000, ill_rec, "ill_hold");
    drain();
    check_count("ill_count");

    // Clear during T4 of add: no strobes that cycle, IDLE afterwards.
    do_clear();
    push(1'b0, 1'b1, 32'h0, idle_rec, "abort_idle");
    push_instr(32'h1A920000, 0, 1'b1, 4, "abort_add");
    drain();
    Clear = 1'b1;
    @(negedge Clock);
    got = sample();
    check_obs("abort_clear_t4", got, idle_rec);
    @(posedge Clock); #1;
    Clear = 1'b0; Run = 1'b0;
    push(1'b0, 1'b0, 32'h1A920000, idle_rec, "abort_after1");
    push(1'b0, 1'b0, 32'h1A920000, idle_rec, "abort_after2");
    drain();
    exp_count = 0;
    check_count("abort_count");

    // Counter wrap on the 3-bit instance after 8 nops.
    do_clear();
    push(1'b0, 1'b1, 32'h0, idle_rec, "wrap_idle");
    for (int i = 0; i < 7; i++) push_instr(mk(5'b11010, 4'd0, 4'd0, 4'd0), 0, 1'b1, 0, "wnop");
    drain();
    check_count("wrap_7");
    push_instr(mk(5'b11010, 4'd0, 4'd0, 4'd0), 0, 1'b0, 0, "wnop8");
    drain();
    check_count("wrap_8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
